// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 types, round constants and GF(2^8) arithmetic
//   state_t    128-bit cipher state / round key
//   word_t     32-bit key-schedule word
//   NUM_ROUNDS number of AES-128 rounds
//   RCON       key-schedule round constants, rounds 1..10
//   gf_mul     multiply in GF(2^8) modulo x^8+x^4+x^3+x+1
package aes_pkg;
    typedef logic [127:0] state_t;
    typedef logic [31:0] word_t;
    localparam int NUM_ROUNDS = 10;
    localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                           8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = xtime(x);
        end
        return p;
    endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box
//   a  in  8  input byte
//   s  out 8  substituted byte
// The inverse is a^254 (maps 0 to 0), followed by the FIPS-197 affine transform.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] s
);
    logic [7:0] sq;
    logic [7:0] inv;
    always_comb begin
        sq = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
    end
    assign s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

// File: rtl/add_round_key_iter.sv
// add_round_key_iter: AES-128 AddRoundKey stage with on-the-fly key expansion
//   clk, rst_n          clock, asynchronous active-low reset
//   key_load, key_in    load master key and restart at round 0
//   in_valid, in_data   state to whiten; in_ready accepts it
//   out_valid, out_data whitened state; out_round is the key's round index,
//   out_round, out_last out_last marks round 10; out_ready drains the register
module add_round_key_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_load,
    input  logic [127:0] key_in,
    input  logic         in_valid,
    input  logic [127:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [127:0] out_data,
    output logic [3:0]   out_round,
    output logic         out_last,
    input  logic         out_ready
);
    localparam logic [3:0] LAST = 4'(NUM_ROUNDS);
    state_t master;
    state_t rk;
    state_t next_rk;
    logic [3:0] round;
    logic key_ok;
    logic accept;
    logic [7:0] rcon;
    word_t rot;
    word_t sub;
    word_t t;
    word_t w0n;
    word_t w1n;
    word_t w2n;
    word_t w3n;
    assign rot = {rk[23:0], rk[31:24]};
    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_sub
            aes_sbox u_sbox (.a(rot[8*i +: 8]), .s(sub[8*i +: 8]));
        end
    endgenerate
    // index is clamped in the last round, where next_rk is not used
    assign rcon = RCON[(round >= LAST) ? LAST : round + 4'd1];
    assign t = sub ^ {rcon, 24'h0};
    assign w0n = rk[127:96] ^ t;
    assign w1n = rk[95:64] ^ w0n;
    assign w2n = rk[63:32] ^ w1n;
    assign w3n = rk[31:0] ^ w2n;
    assign next_rk = {w0n, w1n, w2n, w3n};
    assign in_ready = key_ok && !key_load && (!out_valid || out_ready);
    assign accept = in_valid && in_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            master <= '0;
            rk <= '0;
            round <= '0;
            key_ok <= 1'b0;
            out_valid <= 1'b0;
            out_data <= '0;
            out_round <= '0;
            out_last <= 1'b0;
        end else if (key_load) begin
            master <= key_in;
            rk <= key_in;
            round <= '0;
            key_ok <= 1'b1;
            out_valid <= 1'b0;
        end else if (accept) begin
            out_data <= in_data ^ rk;
            out_round <= round;
            out_last <= (round == LAST);
            out_valid <= 1'b1;
            rk <= (round == LAST) ? master : next_rk;
            round <= (round == LAST) ? 4'd0 : round + 4'd1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
